// File: rtl/ihex_loader.sv
// rtl/ihex_loader.sv - Raw binary / Intel HEX image loader from the ioctl download stream into program memory
//
// Ports:
//   clk_sys, reset_n          system clock, asynchronous active-low reset
//   ioctl_download/wr/addr/dout/index
//                             download stream (one byte per ioctl_wr strobe)
//   mem_we/addr/bsel/data     one-cycle byte write into the target memory
//   busy, done                download in progress / finished until the next download
//   err_checksum/format/range sticky error flags, cleared when a new download starts
module ihex_loader #(
    parameter int          ADDR_W     = 15,
    parameter int          WORD_BYTES = 2,
    parameter int          IOCTL_AW   = 25,
    parameter logic [7:0]  RAW_INDEX  = 8'd0,
    localparam int         LOG2WB     = $clog2(WORD_BYTES),
    localparam int         BSEL_W     = (LOG2WB > 0) ? LOG2WB : 1,
    localparam int         MA_W       = ADDR_W - LOG2WB
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [7:0]          ioctl_index,
    output logic                mem_we,
    output logic [MA_W-1:0]     mem_addr,
    output logic [BSEL_W-1:0]   mem_bsel,
    output logic [7:0]          mem_data,
    output logic                busy,
    output logic                done,
    output logic                err_checksum,
    output logic                err_format,
    output logic                err_range
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM, S_EOF
    } state_t;

    state_t      state;
    logic        dl_q;
    logic        raw_mode;
    logic        eof_seen;
    logic        lo_nib;      // next hex digit completes a byte
    logic [3:0]  hi_nib;
    logic [7:0]  rec_len;
    logic [7:0]  rec_type;
    logic [7:0]  cnt;         // byte index within ADDR / DATA fields
    logic [7:0]  sum;
    logic [15:0] rec_addr;
    logic [15:0] data16;
    logic [31:0] base;

    logic        is_hex;
    logic [3:0]  nib;
    logic [7:0]  cur_byte;
    logic [7:0]  sum_next;
    logic [15:0] rec_off;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        emit;
    logic        in_range;

    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (ioctl_dout >= 8'h30 && ioctl_dout <= 8'h39)
            nib = ioctl_dout[3:0];
        else if ((ioctl_dout >= 8'h41 && ioctl_dout <= 8'h46) ||
                 (ioctl_dout >= 8'h61 && ioctl_dout <= 8'h66))
            nib = ioctl_dout[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    assign cur_byte = {hi_nib, nib};
    assign sum_next = sum + cur_byte;
    // Record offset wraps at 16 bits before the base is added.
    assign rec_off  = rec_addr + {8'h00, cnt};
    assign wr_addr  = raw_mode ? 32'(ioctl_addr) : base + {16'h0000, rec_off};
    assign wr_data  = raw_mode ? ioctl_dout : cur_byte;
    assign in_range = (wr_addr >> ADDR_W) == 32'd0;
    // Strobes are only honoured once the start edge has been registered.
    assign wr_en    = ioctl_wr & ioctl_download & dl_q;
    assign emit     = wr_en & (raw_mode |
                      (state == S_DATA && lo_nib && is_hex && rec_type == 8'h00));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            dl_q         <= 1'b0;
            raw_mode     <= 1'b0;
            eof_seen     <= 1'b0;
            lo_nib       <= 1'b0;
            hi_nib       <= 4'h0;
            rec_len      <= 8'h00;
            rec_type     <= 8'h00;
            cnt          <= 8'h00;
            sum          <= 8'h00;
            rec_addr     <= 16'h0000;
            data16       <= 16'h0000;
            base         <= 32'h0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_bsel     <= '0;
            mem_data     <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_checksum <= 1'b0;
            err_format   <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            dl_q   <= ioctl_download;
            mem_we <= 1'b0;

            if (emit) begin
                if (in_range) begin
                    mem_we   <= 1'b1;
                    mem_addr <= MA_W'(wr_addr >> LOG2WB);
                    mem_bsel <= wr_addr[BSEL_W-1:0] & BSEL_W'(WORD_BYTES - 1);
                    mem_data <= wr_data;
                end else begin
                    err_range <= 1'b1;
                end
            end

            if (ioctl_download && !dl_q) begin
                busy         <= 1'b1;
                done         <= 1'b0;
                err_checksum <= 1'b0;
                err_format   <= 1'b0;
                err_range    <= 1'b0;
                base         <= 32'h0;
                eof_seen     <= 1'b0;
                state        <= S_IDLE;
                raw_mode     <= (ioctl_index == RAW_INDEX);
            end else if (!ioctl_download && dl_q) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (!raw_mode && !eof_seen)
                    err_format <= 1'b1;
            end else if (wr_en && !raw_mode) begin
                case (state)
                    S_IDLE: begin
                        if (ioctl_dout == 8'h3A) begin
                            state  <= S_LEN;
                            sum    <= 8'h00;
                            lo_nib <= 1'b0;
                        end
                    end
                    S_EOF: ;
                    default: begin
                        if (!is_hex) begin
                            err_format <= 1'b1;
                            state      <= S_IDLE;
                        end else if (!lo_nib) begin
                            hi_nib <= nib;
                            lo_nib <= 1'b1;
                        end else begin
                            lo_nib <= 1'b0;
                            sum    <= sum_next;
                            case (state)
                                S_LEN: begin
                                    rec_len <= cur_byte;
                                    cnt     <= 8'h00;
                                    state   <= S_ADDR;
                                end
                                S_ADDR: begin
                                    if (cnt == 8'h00) begin
                                        rec_addr[15:8] <= cur_byte;
                                        cnt            <= 8'h01;
                                    end else begin
                                        rec_addr[7:0] <= cur_byte;
                                        state         <= S_TYPE;
                                    end
                                end
                                S_TYPE: begin
                                    rec_type <= cur_byte;
                                    cnt      <= 8'h00;
                                    if (cur_byte > 8'h05 ||
                                        ((cur_byte == 8'h02 || cur_byte == 8'h04) &&
                                         rec_len != 8'h02)) begin
                                        err_format <= 1'b1;
                                        state      <= S_IDLE;
                                    end else if (rec_len == 8'h00) begin
                                        state <= S_CSUM;
                                    end else begin
                                        state <= S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    if (cnt == 8'h00)
                                        data16[15:8] <= cur_byte;
                                    else if (cnt == 8'h01)
                                        data16[7:0] <= cur_byte;
                                    cnt <= cnt + 8'd1;
                                    if (cnt + 8'd1 == rec_len)
                                        state <= S_CSUM;
                                end
                                S_CSUM: begin
                                    if (sum_next != 8'h00)
                                        err_checksum <= 1'b1;
                                    else if (rec_type == 8'h02)
                                        base <= {12'h000, data16, 4'h0};
                                    else if (rec_type == 8'h04)
                                        base <= {data16, 16'h0000};
                                    if (rec_type == 8'h01) begin
                                        eof_seen <= 1'b1;
                                        state    <= S_EOF;
                                    end else begin
                                        state <= S_IDLE;
                                    end
                                end
                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ihex_loader.sv
// tb/tb_ihex_loader.sv - Directed self-checking bench for ihex_loader (raw and Intel HEX modes)
module tb_ihex_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [0:0]  mem_bsel;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        err_checksum;
    logic        err_format;
    logic        err_range;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;
    int nw    = 0;
    int wbase;
    logic [31:0] foff;
    logic [31:0] log_a [0:63];
    logic [31:0] log_b [0:63];
    logic [31:0] log_d [0:63];

    ihex_loader #(
        .ADDR_W(15), .WORD_BYTES(2), .IOCTL_AW(25), .RAW_INDEX(8'd0)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_bsel(mem_bsel),
        .mem_data(mem_data),
        .busy(busy),
        .done(done),
        .err_checksum(err_checksum),
        .err_format(err_format),
        .err_range(err_range)
    );

    always #5 clk_sys = ~clk_sys;

    // Write logger, sampled just after each rising edge.
    always @(posedge clk_sys) begin
        #1;
        if (mem_we === 1'b1 && nw < 64) begin
            log_a[nw] = 32'(mem_addr);
            log_b[nw] = 32'(mem_bsel);
            log_d[nw] = 32'(mem_data);
            nw = nw + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk = nchk + 1;
        assert (obs === exp) npass = npass + 1;
        else begin
            nfail = nfail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        if (idx < nw) begin
            check({tag, "_addr"}, log_a[idx], a);
            check({tag, "_bsel"}, log_b[idx], b);
            check({tag, "_data"}, log_d[idx], d);
        end else begin
            check({tag, "_present"}, 32'(nw), 32'(idx + 1));
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(foff);
        ioctl_dout = c;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        foff = foff + 32'd1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_char(s[i]);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        foff = 32'd0;
    endtask

    task automatic end_dl;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        ioctl_index    = 8'h00;
        foff           = 32'd0;
        repeat (2) @(negedge clk_sys);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_errs", {29'd0, err_checksum, err_format, err_range}, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Raw mode; index change mid-download must not change the mode.
        start_dl(8'd0);
        check("raw_busy", 32'(busy), 1);
        ioctl_index = 8'd5;
        send_char(8'h11);
        check("raw0_we", 32'(mem_we), 1);
        check("raw0", {mem_addr, 1'b0, mem_bsel, 8'd0, mem_data}, {14'd0, 1'b0, 1'b0, 8'd0, 8'h11});
        send_char(8'h22);
        check("raw1", {mem_we, mem_addr, mem_bsel, mem_data}, {1'b1, 14'd0, 1'b1, 8'h22});
        send_char(8'h33);
        check("raw2", {mem_we, mem_addr, mem_bsel, mem_data}, {1'b1, 14'd1, 1'b0, 8'h33});
        @(negedge clk_sys);
        check("raw_we_pulse", 32'(mem_we), 0);
        end_dl;
        check("raw_done", {busy, done}, 2'b01);
        check("raw_errs", {err_checksum, err_format, err_range}, 3'b000);

        // Raw range boundary.
        start_dl(8'd0);
        foff = 32'h7FFF;
        send_char(8'h55);
        check("raw_top", {mem_we, mem_addr, mem_bsel, mem_data}, {1'b1, 14'h3FFF, 1'b1, 8'h55});
        check("raw_top_range", 32'(err_range), 0);
        send_char(8'h44);
        check("raw_oor_we", 32'(mem_we), 0);
        check("raw_oor_range", 32'(err_range), 1);
        end_dl;

        // Basic HEX image.
        start_dl(8'd1);
        check("hexA_clear", {done, err_range}, 2'b00);
        wbase = nw;
        send_str(":02000000AA55FF");
        send_str(":00000001FF");
        check("hexA_nw", 32'(nw - wbase), 2);
        check_log("hexA_w0", wbase, 0, 0, 32'hAA);
        check_log("hexA_w1", wbase + 1, 0, 1, 32'h55);
        end_dl;
        check("hexA_done", {busy, done}, 2'b01);
        check("hexA_errs", {err_checksum, err_format, err_range}, 3'b000);

        // Upper and lower case digits.
        start_dl(8'd1);
        wbase = nw;
        send_str(":0100100012DD");
        send_str(":0100100012dd");
        send_str(":00000001FF");
        check("hexB_nw", 32'(nw - wbase), 2);
        check_log("hexB_up", wbase, 8, 0, 32'h12);
        check_log("hexB_lo", wbase + 1, 8, 0, 32'h12);
        end_dl;
        check("hexB_errs", {err_checksum, err_format, err_range}, 3'b000);

        // Bad checksum: writes stay, flag sticks past done.
        start_dl(8'd1);
        wbase = nw;
        send_str(":02000000AA5500");
        check("hexC_csum_now", 32'(err_checksum), 1);
        send_str(":00000001FF");
        check("hexC_nw", 32'(nw - wbase), 2);
        end_dl;
        check("hexC_after_done", {done, err_checksum, err_format}, 3'b110);

        // Extended linear address pushes writes out of range.
        start_dl(8'd1);
        wbase = nw;
        send_str(":020000040001F9");
        send_str(":0100000012ED");
        send_str(":00000001FF");
        check("hexD_nw", 32'(nw - wbase), 0);
        check("hexD_range", 32'(err_range), 1);
        check("hexD_csum", 32'(err_checksum), 0);
        end_dl;

        // Next download clears err_range; segment base and 16-bit offset wrap.
        start_dl(8'd1);
        check("hexE_clear", 32'(err_range), 0);
        wbase = nw;
        send_str(":020000020100FB");
        send_str(":010005007783");
        send_str(":02FFFF00AABB9B");
        send_str(":00000001FF");
        check("hexE_nw", 32'(nw - wbase), 2);
        check_log("hexE_seg", wbase, 32'h802, 1, 32'h77);
        check_log("hexE_wrap", wbase + 1, 32'h800, 0, 32'hBB);
        check("hexE_range", 32'(err_range), 1);
        end_dl;
        check("hexE_errs", {err_checksum, err_format}, 2'b00);

        // Bad character aborts the record; parser resyncs on ':'.
        start_dl(8'd1);
        wbase = nw;
        send_str(":0100G");
        check("hexF_fmt", 32'(err_format), 1);
        send_str("0012DD");
        send_str(":0100200034AB");
        send_str(":00000001FF");
        check("hexF_nw", 32'(nw - wbase), 1);
        check_log("hexF_resync", wbase, 32'h10, 0, 32'h34);
        end_dl;
        check("hexF_end", {done, err_format}, 2'b11);

        // Reset mid-record, then a download that ends without EOF.
        start_dl(8'd1);
        wbase = nw;
        send_str(":01003000");
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check("rstmid_outs", {mem_we, busy, done, err_checksum, err_format, err_range}, 6'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        send_str("5675");
        check("rstmid_nw", 32'(nw - wbase), 0);
        end_dl;
        check("noeof_end", {done, err_format}, 2'b11);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/ihex_loader.md
Name: ihex_loader

Overview:
- Parametrised ROM/RAM image loader in the clk_sys domain, between hps_io's ioctl download stream and a core's program memory.
- Raw binary images are written straight through. Intel HEX images are fully parsed: record types 00–05, upper- and lower-case hex, checksum verification, extended segment/linear addressing, and sticky error reporting.
- Generalises the inline single-width HEX parser used by the cores so each core instantiates one block with its own address and word width.

Parameters:
- ADDR_W, 15, byte-address width of the target memory; target size is 2^ADDR_W bytes.
- WORD_BYTES, 2, bytes per memory word; must be a power of two (1, 2, 4).
- IOCTL_AW, 25, width of ioctl_addr.
- RAW_INDEX, 0, ioctl_index value selecting raw binary mode; any other index selects HEX mode.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  one-cycle strobe; ioctl_dout is valid on it.
- ioctl_addr  in  IOCTL_AW  file byte offset.
- ioctl_dout  in  8  file byte.
- ioctl_index  in  8  file type index.
- mem_we  out  1  one-cycle byte write strobe.
- mem_addr  out  ADDR_W-log2(WORD_BYTES)  word address.
- mem_bsel  out  log2(WORD_BYTES) (min 1)  byte lane within the word.
- mem_data  out  8  byte to write.
- busy  out  1  download in progress.
- done  out  1  high from end of download until the next download starts.
- err_checksum  out  1  sticky; a record's checksum was non-zero.
- err_format  out  1  sticky; bad character, truncated record, or no EOF record.
- err_range  out  1  sticky; a write was suppressed because its address was ≥ 2^ADDR_W.

Behaviour:
- Reset (async, reset_n=0): every output 0, parser state IDLE, base address 0.
- Download start (ioctl_download 0→1, registered edge):
  - Clear done, all err_*, and the base address; parser goes to IDLE.
  - busy=1 from the following cycle.
- Download end (1→0):
  - busy=0, done=1 on the next cycle.
  - In HEX mode with no EOF record seen, err_format=1 on that same cycle.
- Raw mode: each ioctl_wr with byte address ioctl_addr gives, one cycle later:
  - mem_we=1, mem_data=ioctl_dout, mem_addr=addr[ADDR_W-1:log2 WB], mem_bsel=addr[log2 WB-1:0].
  - If ioctl_addr ≥ 2^ADDR_W: mem_we stays 0 and err_range is set.
- HEX mode parser, advancing only on ioctl_wr:
  - IDLE: ':' goes to LEN_H. Any other character is ignored.
  - Field states: LEN(2 digits), ADDR(4), TYPE(2), DATA(2·LEN), CSUM(2).
  - Hex digits '0'-'9', 'A'-'F' and 'a'-'f' are accepted. Any other character inside a record sets err_format and returns to IDLE; no further writes come from that record.
  - A running 8-bit sum covers every byte from LEN through CSUM. At the end of CSUM, a non-zero sum sets err_checksum. Writes already issued are not retracted.
  - LEN=0 skips DATA.
- Record types:
  - 00 data: each completed data byte, at the second digit's ioctl_wr, produces mem_we one cycle later at byte address base + ADDR + offset (32-bit arithmetic). Range rule as in raw mode.
  - 01 EOF: records eof_seen. Characters after it are ignored until the next download.
  - 02 extended segment: base = data16 << 4.
  - 04 extended linear: base = data16 << 16.
  - 02 and 04 update the base only if the checksum passes. LEN≠2 sets err_format and leaves base unchanged.
  - 03, 05: parsed and checksummed, no effect.
  - Any other type: err_format.
- ADDR field wrap: the record offset wraps at 16 bits (ADDR + offset mod 2^16) before base is added.
- mem_we never asserts while ioctl_download=0 or in the cycle of the start edge.
- If the index changes mid-download, the mode latched at the start edge is used.
- reset_n asserted mid-record aborts immediately; a partial record produces no further writes.

Test Plan:
- Raw, WORD_BYTES=2: bytes 0x11,0x22,0x33 at addr 0..2 → writes (word0,bsel0,11), (word0,bsel1,22), (word1,bsel0,33), each one cycle after ioctl_wr; done=1 after download end; all err=0.
- HEX ":02000000AA55FF", ":00000001FF" → writes word0/bsel0=AA, word0/bsel1=55; done=1, no errors.
- HEX ":0100100012DD" with lower-case variant ":0100100012dd" → byte 0x0010 written 0x12 (word 8, bsel0) both times.
- HEX ":02000000AA5500" → both bytes written, err_checksum=1 at CSUM end and still 1 after done.
- HEX ":020000040001F9" then ":0100000012ED" with ADDR_W=15 → no mem_we, err_range=1. A following new download clears err_range.
- HEX ":0100G0..." → err_format=1, parser returns to IDLE. reset_n pulse mid-record → all outputs 0, no write from that record. Download ending without ":00000001FF" → err_format=1.
